// File: rtl/cnn_pkg.sv
// Shared CNN types and constants: kernel size, pixel width, window layout
// used by conv_window_gen and the convolution datapath, plus window FSM states.
package cnn_pkg;

  localparam int unsigned KSIZE  = 5;
  localparam int unsigned DATA_W = 16;

  typedef logic signed [DATA_W-1:0] pixel_t;
  typedef pixel_t window_t [0:KSIZE-1][0:KSIZE-1];

  typedef enum logic {
    ST_FILL,
    ST_RUN
  } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// Single-port row RAM, read-before-write: rdata shows the old contents at addr
// during the cycle in which the same address is written.
module line_buffer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Asynchronous read returns the value stored before this cycle's write.
  always_comb rdata = mem[addr];

  // Write the incoming row sample at the current column.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 5x5 window generator for the convolution datapath.
// Optional feature: define CONV_WINDOW_STRIDE2_EN to emit only windows whose
// origin row and column are both even (stride 2).
module conv_window_gen
  import cnn_pkg::*;
#(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned DATA_W = 16
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic signed [DATA_W-1:0]               in_data,
  output logic                                   win_valid,
  input  logic                                   win_ready,
  output logic [0:KSIZE-1][0:KSIZE-1][DATA_W-1:0] window,
  output logic                                   win_last,
  output logic                                   frame_done
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
`ifdef CONV_WINDOW_STRIDE2_EN
  localparam bit STRIDE2 = 1'b1;
`else
  localparam bit STRIDE2 = 1'b0;
`endif
  // Position of the pixel completing the last emitted window of a frame.
  localparam int unsigned LAST_R = STRIDE2 ? ((IMG_H - 5) / 2) * 2 + 4 : IMG_H - 1;
  localparam int unsigned LAST_C = STRIDE2 ? ((IMG_W - 5) / 2) * 2 + 4 : IMG_W - 1;

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  win_state_t     state, state_nxt;
  logic           xfer, col_last, row_last;
  logic           emit, frame_done_nxt, last_win, stride_ok;
  logic [DATA_W-1:0] lb_wd [0:3];
  logic [DATA_W-1:0] lb_rd [0:3];
  logic [0:KSIZE-1][0:KSIZE-1][DATA_W-1:0] sw, sw_nxt;

  assign in_ready = !win_valid || win_ready;
  assign xfer     = in_valid && in_ready;
  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));

  // Line buffers cascade vertically: each row RAM takes the one below it.
  always_comb begin
    lb_wd[0] = in_data;
    for (int unsigned k = 1; k < 4; k++) lb_wd[k] = lb_rd[k-1];
  end

  for (genvar k = 0; k < 4; k++) begin : g_lb
    line_buffer #(.DEPTH(IMG_W), .WIDTH(DATA_W)) u_lb (
      .clk   (clk),
      .we    (xfer),
      .addr  (col),
      .wdata (lb_wd[k]),
      .rdata (lb_rd[k])
    );
  end

  // Shift array moves left one column; new right column is oldest row on top.
  always_comb begin
    sw_nxt = sw;
    for (int unsigned i = 0; i < KSIZE; i++) begin
      for (int unsigned j = 0; j < KSIZE - 1; j++) sw_nxt[i][j] = sw[i][j+1];
    end
    sw_nxt[0][4] = lb_rd[3];
    sw_nxt[1][4] = lb_rd[2];
    sw_nxt[2][4] = lb_rd[1];
    sw_nxt[3][4] = lb_rd[0];
    sw_nxt[4][4] = in_data;
  end

  // Column/row position of the next pixel to be accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (xfer) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_FILL;
    else     state <= state_nxt;
  end

  // FSM next state: FILL until row 4 starts, RUN until the frame wraps.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL: if (xfer && col_last && row == RW'(3)) state_nxt = ST_RUN;
      ST_RUN:  if (xfer && col_last && row_last)      state_nxt = ST_FILL;
      default: state_nxt = ST_FILL;
    endcase
  end

  // FSM outputs: window emission and end-of-frame detection.
  always_comb begin
    // Origin parity equals row/col parity since the offset (4) is even.
    stride_ok      = !STRIDE2 || (!row[0] && !col[0]);
    emit           = xfer && (state == ST_RUN) && (col >= CW'(4)) && stride_ok;
    last_win       = (row == RW'(LAST_R)) && (col == CW'(LAST_C));
    frame_done_nxt = xfer && (state == ST_RUN) && col_last && row_last;
  end

  // Shift array, output window register and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw         <= '0;
      window     <= '0;
      win_valid  <= 1'b0;
      win_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_done_nxt;
      if (xfer) sw <= sw_nxt;
      if (emit) begin
        window    <= sw_nxt;
        win_valid <= 1'b1;
        win_last  <= last_win;
      end else if (win_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on an 8x8 frame with pixel = row*8+col.
module tb_conv_window_gen;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DW = 16;
`ifdef CONV_WINDOW_STRIDE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int NC = (W - 4 + S - 1) / S;
  localparam int NR = (H - 4 + S - 1) / S;
  localparam int N  = NR * NC;

  logic clk = 1'b0;
  logic rst, in_valid, in_ready, win_valid, win_ready, win_last, frame_done;
  logic signed [DW-1:0] in_data;
  logic [0:4][0:4][DW-1:0] window;

  int total = 0;
  int bad   = 0;
  int brow, bcol, exp_k, nwin, acc_cnt, cyc;
  logic exp_valid, exp_fd;

  conv_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .window     (window),
    .win_last   (win_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    int nz;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; win_ready = 1'b1; in_data = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_win_last", win_last, 0);
    chk("rst_frame_done", frame_done, 0);
    nz = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        if (window[i][j] !== '0) nz++;
    chk("rst_window_nonzero", nz, 0);
    brow = 0; bcol = 0; exp_k = 0; exp_valid = 1'b0; exp_fd = 1'b0;
  endtask

  // One clock of stimulus plus checks against the bench's own model.
  task automatic cycle(input logic iv, input logic wr);
    int r, c, werr;
    logic acc, compl, consume;
    @(negedge clk);
    in_valid = iv; win_ready = wr; in_data = DW'(brow * W + bcol);
    #1;
    cyc++;
    chk("win_valid", win_valid, exp_valid);
    chk("frame_done", frame_done, exp_fd);
    chk("in_ready", in_ready, (!exp_valid || wr));
    consume = exp_valid && wr;
    if (consume) begin
      r = (exp_k / NC) * S;
      c = (exp_k % NC) * S;
      werr = 0;
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          if (window[i][j] !== DW'((r + i) * W + c + j)) werr++;
      chk("win_elems_wrong", werr, 0);
      chk("win_00", window[0][0], r * W + c);
      chk("win_44", window[4][4], (r + 4) * W + c + 4);
      chk("win_last", win_last, (exp_k == N - 1));
      nwin++;
      exp_k = (exp_k + 1) % N;
    end
    acc   = iv && (!exp_valid || wr);
    compl = acc && brow >= 4 && bcol >= 4 && (S == 1 || (brow % 2 == 0 && bcol % 2 == 0));
    exp_fd = acc && brow == H - 1 && bcol == W - 1;
    if (compl)        exp_valid = 1'b1;
    else if (consume) exp_valid = 1'b0;
    if (acc) begin
      acc_cnt++;
      if (bcol == W - 1) begin
        bcol = 0;
        brow = (brow == H - 1) ? 0 : brow + 1;
      end else begin
        bcol++;
      end
    end
  endtask

  // mode 0: back-to-back, 1: random win_ready, 2: in_valid idle every other cycle
  task automatic run(input int npix, input int mode);
    int start, guard;
    logic iv, wr;
    start = acc_cnt;
    guard = 0;
    while (acc_cnt - start < npix && guard < npix * 8 + 50) begin
      iv = (mode == 2) ? logic'(cyc % 2) : 1'b1;
      wr = (mode == 1) ? logic'($urandom_range(0, 1)) : 1'b1;
      cycle(iv, wr);
      guard++;
    end
    chk("run_pixels_accepted", acc_cnt - start, npix);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; win_ready = 1'b1; in_data = '0;
    nwin = 0; acc_cnt = 0; cyc = 0;
    do_reset();

    run(64, 0); drain(4);
    chk("base_nwin", nwin, N); nwin = 0;

    run(64, 1); drain(6);
    chk("bp_nwin", nwin, N); nwin = 0;

    run(64, 2); drain(4);
    chk("gap_nwin", nwin, N); nwin = 0;

    run(30, 0);
    do_reset();
    nwin = 0;
    run(64, 0); drain(4);
    chk("after_rst_nwin", nwin, N); nwin = 0;

    run(128, 0); drain(4);
    chk("two_frames_nwin", nwin, 2 * N);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
